fp_export_result_pipe: RTL and testbench
========================================

# fp_export_result_pipe

Parametrised, pipelined special-value resolver for the floating-point ALU. Takes operands A/B, the opcode and the raw datapath result, classifies both operands (zero/inf/NaN), and emits the IEEE-style final result for add, sub, mul or div. It has a two-stage valid/ready pipeline and optional sticky exception flags. It sits between the add/sub, mul and div datapaths and the ALU output register.

## Interface
- EXP_W, default 8: exponent width.
- MAN_W, default 23: mantissa width; word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- op  in  2  00 add, 01 sub, 10 mul, 11 div.
- a, b, temp_result  in  W  operands and raw datapath result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- result  out  W  final result.
- flag_invalid, flag_dz  out  1  per-result invalid / divide-by-zero.
- flag_clr  in  1  clears sticky flags.
- sticky_invalid, sticky_dz  out  1  accumulated flags.

## Operation
- Classification: zero = exp==0 (denormals flushed to zero); inf = exp all-ones, man==0; NaN = exp all-ones, man!=0.
- qNaN = {0, all-ones exp, all-ones man} (0x7FFFFFFF at default). Inf(s) = {s, all-ones exp, 0}. Zero(s) = {s, 0}.
- Any NaN operand -> qNaN, flag_invalid=1, all ops.
- Add/sub: b_eff = b with sign inverted for sub.
  - inf+inf: same sign -> that inf; opposite -> qNaN, invalid.
  - A is inf -> that inf; b_eff is inf -> inf with b_eff sign.
  - both zero -> Zero(a.s & b_eff.s).
  - A zero -> b_eff; b_eff zero -> a.
- Mul: s = a.s^b.s. 0*inf -> qNaN, invalid; inf involved -> Inf(s); zero involved -> Zero(s).
- Div: s = a.s^b.s. 0/0 or inf/inf -> qNaN, invalid; finite nonzero /0 -> Inf(s), flag_dz; inf/x -> Inf(s); x/inf or 0/x -> Zero(s).
- Otherwise -> temp_result unchanged, flags 0.
- Stage 1 registers class bits, signs, op and temp_result. Stage 2 registers the selected result and flags.

## Timing
- Latency 2 cycles from an in_valid&in_ready beat to out_valid, with out_ready high. Throughput 1 beat/cycle.
- Each stage advances when it is empty or the next stage advances. in_ready = !s1_valid | s1_advance. No bubbles under steady flow, no loss under backpressure.
- While out_valid & !out_ready: result, flags and out_valid are held stable.
- Reset (async assert, sync deassert assumed by the system): out_valid=0, result=0, flag_invalid=0, flag_dz=0, sticky_*=0, stage valids 0, and in_ready=1 in the first cycle after reset. In-flight beats are dropped on reset mid-operation.
- Sticky flags are set on an output handshake (out_valid&out_ready) whose flag is 1. flag_clr clears on the next edge. If set and clr occur in the same cycle, set wins.

## Configuration
- FP_EXPORT_STICKY_EN defined: sticky_invalid/sticky_dz registers and the flag_clr behaviour are present.
- Not defined: sticky_* are tied to 0 and flag_clr is ignored. Per-result flags and all other behaviour are unchanged.

## Test plan
- Default widths, op=add, a=0x7F800000, b=0xFF800000 -> 2 cycles later result=0x7FFFFFFF, flag_invalid=1. Sticky_invalid=1 after handshake (macro on).
- op=sub, a=0x00000000, b=0x3F800000, temp_result=0xDEADBEEF -> result=0xBF800000, flags 0.
- op=div, a=0xC0000000, b=0x80000000 -> result=0x7F800000, flag_dz=1.
- op=mul, a=0x40400000, b=0x40000000, temp_result=0x40C00000 -> result=0x40C00000. Then stream 8 beats with out_ready toggling 1010... -> all 8 results in order, none lost or duplicated, outputs stable while stalled.
- Assert rst_n=0 with 2 beats in flight -> out_valid=0 and result=0 immediately, nothing emitted after release. flag_clr in the same cycle as an invalid handshake -> sticky_invalid stays 1.

Source files
------------

// File: rtl/fp_export_result_pipe.sv
// rtl/fp_export_result_pipe.sv - two-stage IEEE special-value resolver for add/sub/mul/div results
// Optional sticky exception flags are built when FP_EXPORT_STICKY_EN is defined.
module fp_export_result_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [EXP_W+MAN_W:0]   temp_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   flag_invalid,
  output logic                   flag_dz,
  input  logic                   flag_clr,
  output logic                   sticky_invalid,
  output logic                   sticky_dz
);

  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam logic [W-1:0] QNAN = {1'b0, {(W-1){1'b1}}};

  function automatic logic [W-1:0] inf_of(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] zero_of(input logic s);
    return {s, {(W-1){1'b0}}};
  endfunction

  // Input classification; denormals count as zero.
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  always_comb begin
    a_zero = (a[W-2:MAN_W] == '0);
    a_inf  = (&a[W-2:MAN_W]) && !(|a[MAN_W-1:0]);
    a_nan  = (&a[W-2:MAN_W]) &&  (|a[MAN_W-1:0]);
    b_zero = (b[W-2:MAN_W] == '0);
    b_inf  = (&b[W-2:MAN_W]) && !(|b[MAN_W-1:0]);
    b_nan  = (&b[W-2:MAN_W]) &&  (|b[MAN_W-1:0]);
  end

  logic           s1_valid;
  logic [1:0]     s1_op;
  logic [W-1:0]   s1_a, s1_b, s1_tr;
  logic           s1_a_zero, s1_a_inf, s1_a_nan;
  logic           s1_b_zero, s1_b_inf, s1_b_nan;

  logic s2_advance;
  logic out_hs;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign out_hs     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= 2'b00;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_tr     <= '0;
      s1_a_zero <= 1'b0;
      s1_a_inf  <= 1'b0;
      s1_a_nan  <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_b_inf  <= 1'b0;
      s1_b_nan  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op     <= op;
        s1_a      <= a;
        s1_b      <= b;
        s1_tr     <= temp_result;
        s1_a_zero <= a_zero;
        s1_a_inf  <= a_inf;
        s1_a_nan  <= a_nan;
        s1_b_zero <= b_zero;
        s1_b_inf  <= b_inf;
        s1_b_nan  <= b_nan;
      end
    end
  end

  logic [W-1:0] sel_result;
  logic         sel_invalid;
  logic         sel_dz;
  logic         a_s, b_s, b_eff_s, prod_s;

  always_comb begin
    sel_result  = s1_tr;
    sel_invalid = 1'b0;
    sel_dz      = 1'b0;
    a_s         = s1_a[W-1];
    b_s         = s1_b[W-1];
    b_eff_s     = (s1_op == OP_SUB) ? !b_s : b_s;
    prod_s      = a_s ^ b_s;

    if (s1_a_nan || s1_b_nan) begin
      sel_result  = QNAN;
      sel_invalid = 1'b1;
    end else if (s1_op == OP_ADD || s1_op == OP_SUB) begin
      if (s1_a_inf && s1_b_inf) begin
        if (a_s == b_eff_s) begin
          sel_result = inf_of(a_s);
        end else begin
          sel_result  = QNAN;
          sel_invalid = 1'b1;
        end
      end else if (s1_a_inf) begin
        sel_result = inf_of(a_s);
      end else if (s1_b_inf) begin
        sel_result = inf_of(b_eff_s);
      end else if (s1_a_zero && s1_b_zero) begin
        sel_result = zero_of(a_s & b_eff_s);
      end else if (s1_a_zero) begin
        sel_result = {b_eff_s, s1_b[W-2:0]};
      end else if (s1_b_zero) begin
        sel_result = s1_a;
      end
    end else if (s1_op == OP_MUL) begin
      if ((s1_a_zero && s1_b_inf) || (s1_a_inf && s1_b_zero)) begin
        sel_result  = QNAN;
        sel_invalid = 1'b1;
      end else if (s1_a_inf || s1_b_inf) begin
        sel_result = inf_of(prod_s);
      end else if (s1_a_zero || s1_b_zero) begin
        sel_result = zero_of(prod_s);
      end
    end else begin
      // inf/0 falls under inf/x, so only a finite nonzero dividend raises dz.
      if ((s1_a_zero && s1_b_zero) || (s1_a_inf && s1_b_inf)) begin
        sel_result  = QNAN;
        sel_invalid = 1'b1;
      end else if (s1_a_inf) begin
        sel_result = inf_of(prod_s);
      end else if (s1_b_zero) begin
        sel_result = inf_of(prod_s);
        sel_dz     = 1'b1;
      end else if (s1_a_zero || s1_b_inf) begin
        sel_result = zero_of(prod_s);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      result       <= '0;
      flag_invalid <= 1'b0;
      flag_dz      <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result       <= sel_result;
        flag_invalid <= sel_invalid;
        flag_dz      <= sel_dz;
      end
    end
  end

`ifdef FP_EXPORT_STICKY_EN
  // A flag raised by the handshake beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_invalid <= 1'b0;
      sticky_dz      <= 1'b0;
    end else begin
      if (out_hs && flag_invalid) sticky_invalid <= 1'b1;
      else if (flag_clr)          sticky_invalid <= 1'b0;
      if (out_hs && flag_dz)      sticky_dz <= 1'b1;
      else if (flag_clr)          sticky_dz <= 1'b0;
    end
  end
`else
  logic unused_sticky_inputs;
  assign unused_sticky_inputs = flag_clr ^ out_hs;
  assign sticky_invalid = 1'b0;
  assign sticky_dz      = 1'b0;
`endif

endmodule

// File: tb/tb_fp_export_result_pipe.sv
// tb/tb_fp_export_result_pipe.sv - scoreboard bench for fp_export_result_pipe at default widths
module tb_fp_export_result_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  op;
  logic [31:0] a, b, temp_result, result;
  logic        out_valid, out_ready;
  logic        flag_invalid, flag_dz, flag_clr;
  logic        sticky_invalid, sticky_dz;

  fp_export_result_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .temp_result(temp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_invalid(flag_invalid), .flag_dz(flag_dz),
    .flag_clr(flag_clr), .sticky_invalid(sticky_invalid), .sticky_dz(sticky_dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        inv;
    logic        dz;
  } exp_t;

  localparam logic [31:0] QNAN = 32'h7FFF_FFFF;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rmode = 0;
  bit          exp_si = 0, exp_sd = 0;
  bit          stalled = 0;
  logic [33:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // 0 zero, 1 finite nonzero, 2 inf, 3 NaN
  function automatic int kind(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0;
    if (x[30:23] != 8'hFF) return 1;
    return (x[22:0] == 23'd0) ? 2 : 3;
  endfunction

  function automatic exp_t ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] tr);
    exp_t e;
    int   cx, cy;
    bit   xs, ys, s;
    cx = kind(x);
    cy = kind(y);
    e.res = tr; e.inv = 1'b0; e.dz = 1'b0;
    xs = x[31];
    ys = y[31];
    s  = xs ^ ys;
    if (cx == 3 || cy == 3) begin
      e.res = QNAN; e.inv = 1'b1;
    end else if (o == 2'd0 || o == 2'd1) begin
      if (o == 2'd1) ys = !ys;
      if (cx == 2 && cy == 2) begin
        if (xs == ys) e.res = {xs, 31'h7F80_0000};
        else begin e.res = QNAN; e.inv = 1'b1; end
      end
      else if (cx == 2)             e.res = {xs, 31'h7F80_0000};
      else if (cy == 2)             e.res = {ys, 31'h7F80_0000};
      else if (cx == 0 && cy == 0)  e.res = {xs & ys, 31'h0};
      else if (cx == 0)             e.res = {ys, y[30:0]};
      else if (cy == 0)             e.res = x;
    end else if (o == 2'd2) begin
      if (cx + cy == 2 && cx != 1) begin e.res = QNAN; e.inv = 1'b1; end
      else if (cx == 2 || cy == 2)  e.res = {s, 31'h7F80_0000};
      else if (cx == 0 || cy == 0)  e.res = {s, 31'h0};
    end else begin
      if (cx == cy && cx != 1)      begin e.res = QNAN; e.inv = 1'b1; end
      else if (cx == 2)             e.res = {s, 31'h7F80_0000};
      else if (cy == 0)             begin e.res = {s, 31'h7F80_0000}; e.dz = 1'b1; end
      else if (cx == 0 || cy == 2)  e.res = {s, 31'h0};
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    logic [7:0]  ex;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r = {r[31], 31'h0};
      1: r = {r[31], 8'h00, r[22:0]};
      2: r = {r[31], 8'hFF, 23'h0};
      3: r = {r[31], 8'hFF, (r[22:0] == 23'd0) ? 23'd1 : r[22:0]};
      default: begin
        ex = 8'($urandom_range(1, 254));
        r  = {r[31], ex, r[22:0]};
      end
    endcase
    return r;
  endfunction

  task automatic send(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] tr);
    int t = 0;
    op = o; a = x; b = y; temp_result = tr; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end else begin
      sbq.push_back(ref_model(o, x, y, tr));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_pending", sbq.size(), 0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop, stall stability and sticky-flag model.
  always @(negedge clk) begin
    exp_t e;
    bit   si_set, sd_set;
    if (!rst_n) begin
      exp_si  = 0;
      exp_sd  = 0;
      stalled = 0;
    end else begin
      check("sticky_invalid", sticky_invalid, exp_si);
      check("sticky_dz", sticky_dz, exp_sd);
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {result, flag_invalid, flag_dz}, held);
      end
      si_set = 0;
      sd_set = 0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got result %h, expected no output", result);
        end else begin
          e = sbq.pop_front();
          check("result", result, e.res);
          check("flag_invalid", flag_invalid, e.inv);
          check("flag_dz", flag_dz, e.dz);
          si_set = e.inv;
          sd_set = e.dz;
        end
      end
`ifdef FP_EXPORT_STICKY_EN
      exp_si = si_set ? 1'b1 : (flag_clr ? 1'b0 : exp_si);
      exp_sd = sd_set ? 1'b1 : (flag_clr ? 1'b0 : exp_sd);
`endif
      stalled = out_valid && !out_ready;
      held    = {result, flag_invalid, flag_dz};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bit exp_sticky;
`ifdef FP_EXPORT_STICKY_EN
    exp_sticky = 1'b1;
`else
    exp_sticky = 1'b0;
`endif
    rst_n = 1'b0; in_valid = 1'b0; flag_clr = 1'b0;
    op = 2'b00; a = '0; b = '0; temp_result = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {flag_invalid, flag_dz}, 0);
    check("rst_sticky", {sticky_invalid, sticky_dz}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    // inf + -inf, with latency probe and clear colliding with the handshake
    send(2'b00, 32'h7F80_0000, 32'hFF80_0000, $urandom);
    check("latency_early", out_valid, 0);
    @(posedge clk); #1;
    check("latency_out", out_valid, 1);
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    check("sticky_set_wins", sticky_invalid, exp_sticky);
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    check("sticky_cleared", sticky_invalid, 0);

    send(2'b01, 32'h0000_0000, 32'h3F80_0000, 32'hDEAD_BEEF);
    send(2'b11, 32'hC000_0000, 32'h8000_0000, $urandom);
    send(2'b10, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
    drain();

    rmode = 1;
    for (int i = 0; i < 8; i++) send(2'b10, rand_operand(), rand_operand(), $urandom);
    drain();

    rmode = 2;
    for (int i = 0; i < 400; i++) begin
      flag_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), $urandom);
    end
    flag_clr = 1'b0;
    rmode = 0;
    drain();

    // reset with two beats in flight
    rmode = 3;
    @(posedge clk); #1;
    send(2'b00, rand_operand(), rand_operand(), $urandom);
    send(2'b10, rand_operand(), rand_operand(), $urandom);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_in_ready", in_ready, 1);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rmode = 0;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
